// File: rtl/som_pkg.sv
// Shared types and constants for the SOM training controller.
// Neighbourhood bounds honour SOM_TORUS_WRAP_EN (toroidal wrap) when defined.
package som_pkg;

    localparam int GRID_DIM = 8;
    localparam int COORD_W  = 3;
    localparam int VEC_W    = 24;
    localparam int DIST_W   = 11;
    localparam int SHIFT_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEARCH,
        S_UPDATE,
        S_NEXT,
        S_DONE
    } state_t;

    typedef logic signed [3:0] off_t;

    // Lowest offset visited along one axis; planar bounds clip to the grid so
    // out-of-grid cells are never visited at all.
    function automatic off_t sweep_lo(input logic [COORD_W-1:0] c, input logic [2:0] r);
        logic [2:0] m;
`ifdef SOM_TORUS_WRAP_EN
        m = (r > 3'd3) ? 3'd3 : r;
`else
        m = (r < c) ? r : c;
`endif
        return -off_t'({1'b0, m});
    endfunction

    function automatic off_t sweep_hi(input logic [COORD_W-1:0] c, input logic [2:0] r);
        logic [2:0] m;
`ifdef SOM_TORUS_WRAP_EN
        m = (r > 3'd3) ? 3'd3 : r;
`else
        m = (r < (3'd7 - c)) ? r : (3'd7 - c);
`endif
        return off_t'({1'b0, m});
    endfunction

endpackage

// File: rtl/som_nbr_sweep.sv
// Row-major neighbourhood sweep around a latched BMU, producing one cell per advance.
// Planar or toroidal behaviour follows SOM_TORUS_WRAP_EN through the som_pkg bound helpers.
module som_nbr_sweep
    import som_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [COORD_W-1:0] ld_x,
    input  logic [COORD_W-1:0] ld_y,
    input  logic [2:0]         radius,
    input  logic [SHIFT_W-1:0] ep_shift,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [SHIFT_W-1:0] shift,
    output logic               last
);

    logic [COORD_W-1:0] cx, cy;
    off_t               dx, dy;
    off_t               x_lo, x_hi, y_hi;
    logic [2:0]         adx, ady, cheb;
    logic [3:0]         sum;

    assign x_lo = sweep_lo(cx, radius);
    assign x_hi = sweep_hi(cx, radius);
    assign y_hi = sweep_hi(cy, radius);

    always_ff @(posedge clk) begin
        if (rst) begin
            cx <= '0;
            cy <= '0;
            dx <= '0;
            dy <= '0;
        end else if (load) begin
            cx <= ld_x;
            cy <= ld_y;
            dx <= sweep_lo(ld_x, radius);
            dy <= sweep_lo(ld_y, radius);
        end else if (advance) begin
            if (dx == x_hi) begin
                dx <= x_lo;
                dy <= dy + 4'sd1;
            end else begin
                dx <= dx + 4'sd1;
            end
        end
    end

    // Coordinates wrap modulo 8 naturally; planar bounds keep them in-grid.
    always_comb begin
        adx   = dx[3] ? 3'(-dx) : dx[2:0];
        ady   = dy[3] ? 3'(-dy) : dy[2:0];
        cheb  = (adx > ady) ? adx : ady;
        sum   = {1'b0, ep_shift} + {1'b0, cheb};
        shift = sum[3] ? 3'd7 : sum[2:0];
        x     = cx + dx[2:0];
        y     = cy + dy[2:0];
        last  = (dx == x_hi) && (dy == y_hi);
    end

endmodule

// File: rtl/som_train_ctrl.sv
// SOM training sequencer: sample load, VEP search, BMU neighbourhood update, epoch/radius/rate decay.
// Define SOM_TORUS_WRAP_EN for a toroidal neighbourhood (handled in som_nbr_sweep).
module som_train_ctrl
    import som_pkg::*;
#(
    parameter int SAMPLES_PER_EPOCH = 16,
    parameter int NUM_EPOCHS        = 8,
    parameter int R_INIT            = 3,
    parameter int SH_INIT           = 1,
    parameter int SH_MAX            = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VEC_W-1:0]   in_vec,
    output logic               vep_start,
    output logic [VEC_W-1:0]   vep_vec,
    input  logic               vep_done,
    input  logic [COORD_W-1:0] X_c,
    input  logic [COORD_W-1:0] Y_c,
    input  logic [VEC_W-1:0]   weight_c,
    output logic [COORD_W-1:0] bmu_x,
    output logic [COORD_W-1:0] bmu_y,
    output logic               upd_valid,
    input  logic               upd_ready,
    output logic [COORD_W-1:0] upd_x,
    output logic [COORD_W-1:0] upd_y,
    output logic [SHIFT_W-1:0] upd_shift,
    output logic [2:0]         epoch
);

    state_t             state, next_state;
    logic [15:0]        sample_cnt;
    logic [3:0]         epoch_cnt;
    logic [2:0]         radius;
    logic [SHIFT_W-1:0] ep_shift;
    logic               epoch_wrap, sweep_load, advance;
    logic [COORD_W-1:0] sw_x, sw_y;
    logic [SHIFT_W-1:0] sw_shift;
    logic               sw_last;
    logic               unused_weight;

    // The BMU weight is not needed for sequencing.
    assign unused_weight = ^weight_c;

    assign epoch_wrap = (sample_cnt == 16'(SAMPLES_PER_EPOCH - 1));
    assign advance    = upd_valid & upd_ready;
    assign epoch      = epoch_cnt[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            radius     <= 3'(R_INIT);
            ep_shift   <= SHIFT_W'(SH_INIT);
            sample_cnt <= '0;
            epoch_cnt  <= '0;
            vep_vec    <= '0;
            vep_start  <= 1'b0;
            bmu_x      <= '0;
            bmu_y      <= '0;
        end else begin
            state     <= next_state;
            vep_start <= (state == S_LOAD) && in_valid;
            case (state)
                S_IDLE: if (start) begin
                    radius     <= 3'(R_INIT);
                    ep_shift   <= SHIFT_W'(SH_INIT);
                    sample_cnt <= '0;
                    epoch_cnt  <= '0;
                end
                S_LOAD:   if (in_valid) vep_vec <= in_vec;
                S_SEARCH: if (vep_done) begin
                    bmu_x <= X_c;
                    bmu_y <= Y_c;
                end
                S_NEXT: if (epoch_wrap) begin
                    sample_cnt <= '0;
                    epoch_cnt  <= epoch_cnt + 4'd1;
                    radius     <= (radius == 3'd0) ? 3'd0 : radius - 3'd1;
                    ep_shift   <= (ep_shift >= SHIFT_W'(SH_MAX)) ? SHIFT_W'(SH_MAX) : ep_shift + 3'd1;
                end else begin
                    sample_cnt <= sample_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        in_ready   = 1'b0;
        upd_valid  = 1'b0;
        sweep_load = 1'b0;
        case (state)
            S_IDLE:   if (start) next_state = S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) next_state = S_SEARCH;
            end
            S_SEARCH: if (vep_done) begin
                sweep_load = 1'b1;
                next_state = S_UPDATE;
            end
            S_UPDATE: begin
                upd_valid = 1'b1;
                if (upd_ready && sw_last) next_state = S_NEXT;
            end
            S_NEXT: next_state = (epoch_wrap && epoch_cnt == 4'(NUM_EPOCHS - 1)) ? S_DONE : S_LOAD;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign upd_x     = upd_valid ? sw_x : '0;
    assign upd_y     = upd_valid ? sw_y : '0;
    assign upd_shift = upd_valid ? sw_shift : '0;

    som_nbr_sweep u_sweep (
        .clk      (clk),
        .rst      (rst),
        .load     (sweep_load),
        .ld_x     (X_c),
        .ld_y     (Y_c),
        .radius   (radius),
        .ep_shift (ep_shift),
        .advance  (advance),
        .x        (sw_x),
        .y        (sw_y),
        .shift    (sw_shift),
        .last     (sw_last)
    );

endmodule

// File: tb/tb_som_train_ctrl.sv
// Directed bench for som_train_ctrl (SAMPLES_PER_EPOCH=2, NUM_EPOCHS=5); torus test under SOM_TORUS_WRAP_EN.
module tb_som_train_ctrl;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic        vep_done = 1'b0, upd_ready = 1'b0;
    logic [23:0] in_vec = '0, weight_c = '0;
    logic [2:0]  X_c = '0, Y_c = '0;
    logic        busy, done, in_ready, vep_start, upd_valid;
    logic [23:0] vep_vec;
    logic [2:0]  bmu_x, bmu_y, upd_x, upd_y, upd_shift, epoch;

    int errors = 0;
    int checks = 0;
    logic [2:0] got_x[$], got_y[$], got_s[$], exp_x[$], exp_y[$], exp_s[$];

    always #5 clk = ~clk;

    som_train_ctrl #(
        .SAMPLES_PER_EPOCH (2),
        .NUM_EPOCHS        (5),
        .R_INIT            (3),
        .SH_INIT           (1),
        .SH_MAX            (6)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .vep_start(vep_start), .vep_vec(vep_vec), .vep_done(vep_done),
        .X_c(X_c), .Y_c(Y_c), .weight_c(weight_c), .bmu_x(bmu_x), .bmu_y(bmu_y),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_x(upd_x), .upd_y(upd_y),
        .upd_shift(upd_shift), .epoch(epoch)
    );

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_vec(input logic [23:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            in_valid = 1'b1; in_vec = v;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic give_bmu(input logic [2:0] bx, input logic [2:0] by);
        X_c = bx; Y_c = by; vep_done = 1'b1;
        @(negedge clk);
        vep_done = 1'b0; X_c = '0; Y_c = '0;
    endtask

    // Drains one UPDATE phase; rnd toggles upd_ready randomly and tracks stall stability.
    task automatic collect(input bit rnd, output bit to, output int viol);
        bit stalled = 1'b0, seen = 1'b0;
        logic [2:0] hx = '0, hy = '0, hs = '0;
        to = 1'b1; viol = 0;
        got_x.delete(); got_y.delete(); got_s.delete();
        for (int i = 0; i < 2000; i++) begin
            if (!upd_valid && seen) begin to = 1'b0; break; end
            if (upd_valid) begin
                seen = 1'b1;
                if (stalled && (upd_x !== hx || upd_y !== hy || upd_shift !== hs)) viol++;
                upd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (upd_ready) begin
                    got_x.push_back(upd_x); got_y.push_back(upd_y); got_s.push_back(upd_shift);
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1; hx = upd_x; hy = upd_y; hs = upd_shift;
                end
            end
            @(negedge clk);
        end
        upd_ready = 1'b0;
    endtask

    // Reference enumeration straight from the neighbourhood definition.
    task automatic build_exp(input int bx, input int by, input int r, input int sh);
        int rr, x, y, d, s;
        exp_x.delete(); exp_y.delete(); exp_s.delete();
        rr = r;
`ifdef SOM_TORUS_WRAP_EN
        if (rr > 3) rr = 3;
`endif
        for (int dy = -rr; dy <= rr; dy++) begin
            for (int dx = -rr; dx <= rr; dx++) begin
                x = bx + dx; y = by + dy;
`ifdef SOM_TORUS_WRAP_EN
                x = x & 7; y = y & 7;
`else
                if (x < 0 || x > 7 || y < 0 || y > 7) continue;
`endif
                d = ((dx < 0 ? -dx : dx) > (dy < 0 ? -dy : dy)) ? (dx < 0 ? -dx : dx) : (dy < 0 ? -dy : dy);
                s = sh + d;
                if (s > 7) s = 7;
                exp_x.push_back(3'(x)); exp_y.push_back(3'(y)); exp_s.push_back(3'(s));
            end
        end
    endtask

    function automatic int seq_bad();
        int b = 0;
        if (got_x.size() != exp_x.size()) return -1;
        foreach (exp_x[i])
            if (got_x[i] !== exp_x[i] || got_y[i] !== exp_y[i] || got_s[i] !== exp_s[i]) b++;
        return b;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, done, in_ready, vep_start, upd_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, in_ready, vep_start, upd_valid});
        end
        checks++;
        if ({bmu_x, bmu_y, upd_x, upd_y, upd_shift, epoch} !== 18'b0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {bmu_x, bmu_y, upd_x, upd_y, upd_shift, epoch});
        end
        checks++;
        if (vep_vec !== 24'h0) begin errors++; $display("FAIL reset_vec: got %h expected 0", vep_vec); end
    endtask

    task automatic test_corner_bmu();
        bit ok, to; int viol, b;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL start_busy: got busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end
        load_vec(24'hA1B2C3, ok);
        checks++;
        if (!ok || vep_start !== 1'b1 || vep_vec !== 24'hA1B2C3) begin
            errors++; $display("FAIL load: got ok=%b vep_start=%b vec=%h expected 1 1 a1b2c3", ok, vep_start, vep_vec);
        end
        @(negedge clk);
        checks++;
        if (vep_start !== 1'b0) begin errors++; $display("FAIL vep_start_pulse: got %b expected 0", vep_start); end
        give_bmu(3'd0, 3'd0);
        checks++;
        if (in_ready !== 1'b0 || upd_valid !== 1'b1) begin
            errors++; $display("FAIL update_entry: got in_ready=%b upd_valid=%b expected 0 1", in_ready, upd_valid);
        end
        collect(1'b0, to, viol);
        build_exp(0, 0, 3, 1);
        b = seq_bad();
        checks++;
        if (to || b !== 0) begin errors++; $display("FAIL corner_seq: got timeout=%b bad=%0d expected 0 0", to, b); end
`ifndef SOM_TORUS_WRAP_EN
        checks++;
        if (got_x.size() !== 16) begin errors++; $display("FAIL corner_count: got %0d expected 16", got_x.size()); end
        checks++;
        if ({got_x[0], got_y[0], got_s[0]} !== {3'd0, 3'd0, 3'd1}) begin
            errors++; $display("FAIL corner_first: got (%0d,%0d,%0d) expected (0,0,1)", got_x[0], got_y[0], got_s[0]);
        end
        checks++;
        if ({got_x[15], got_y[15], got_s[15]} !== {3'd3, 3'd3, 3'd4}) begin
            errors++; $display("FAIL corner_last: got (%0d,%0d,%0d) expected (3,3,4)", got_x[15], got_y[15], got_s[15]);
        end
`endif
        checks++;
        if (vep_vec !== 24'hA1B2C3) begin errors++; $display("FAIL vec_hold: got %h expected a1b2c3", vep_vec); end
        @(negedge clk);
    endtask

    task automatic test_centre_bmu();
        bit ok, to; int viol, b;
        load_vec(24'h102030, ok);
        give_bmu(3'd4, 3'd4);
        checks++;
        if (bmu_x !== 3'd4 || bmu_y !== 3'd4) begin
            errors++; $display("FAIL bmu_reg: got (%0d,%0d) expected (4,4)", bmu_x, bmu_y);
        end
        collect(1'b0, to, viol);
        build_exp(4, 4, 3, 1);
        b = seq_bad();
        checks++;
        if (to || got_x.size() !== 49 || b !== 0) begin
            errors++; $display("FAIL centre_seq: got n=%0d bad=%0d expected 49 0", got_x.size(), b);
        end
        checks++;
        if ({got_x[0], got_y[0], got_s[0]} !== {3'd1, 3'd1, 3'd4}) begin
            errors++; $display("FAIL centre_corner: got (%0d,%0d,%0d) expected (1,1,4)", got_x[0], got_y[0], got_s[0]);
        end
        checks++;
        if ({got_x[24], got_y[24], got_s[24]} !== {3'd4, 3'd4, 3'd1}) begin
            errors++; $display("FAIL centre_self: got (%0d,%0d,%0d) expected (4,4,1)", got_x[24], got_y[24], got_s[24]);
        end
        @(negedge clk);
        checks++;
        if (epoch !== 3'd1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL epoch_step: got epoch=%0d in_ready=%b expected 1 1", epoch, in_ready);
        end
    endtask

    task automatic test_stall();
        bit ok, to; int viol, b;
        do_reset();
        pulse_start();
        load_vec(24'h0F0F0F, ok);
        give_bmu(3'd6, 3'd2);
        collect(1'b1, to, viol);
        build_exp(6, 2, 3, 1);
        b = seq_bad();
        checks++;
        if (to || b !== 0) begin errors++; $display("FAIL stall_seq: got timeout=%b bad=%0d expected 0 0", to, b); end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL stall_hold: got %0d changes expected 0", viol); end
    endtask

    task automatic test_full_run();
        bit ok, to; int viol, b, e;
        do_reset();
        pulse_start();
        for (int s = 0; s < 10; s++) begin
            e = s / 2;
            checks++;
            if (epoch !== 3'(e)) begin errors++; $display("FAIL run_epoch%0d: got %0d expected %0d", s, epoch, e); end
            load_vec(24'(s), ok);
            give_bmu(3'd4, 3'd4);
            collect(1'b0, to, viol);
            build_exp(4, 4, (3 - e) > 0 ? 3 - e : 0, (1 + e) < 6 ? 1 + e : 6);
            b = seq_bad();
            checks++;
            if (!ok || to || b !== 0) begin
                errors++; $display("FAIL run_sample%0d: got n=%0d bad=%0d expected n=%0d bad=0", s, got_x.size(), b, exp_x.size());
            end
            @(negedge clk);
            if (s < 9) begin
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL early_done%0d: got 1 expected 0", s); end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || epoch !== 3'd5) begin
            errors++; $display("FAIL done_pulse: got done=%b busy=%b epoch=%0d expected 1 1 5", done, busy, epoch);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_end: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_stray_and_rst();
        bit ok;
        do_reset();
        pulse_start();
        X_c = 3'd5; Y_c = 3'd5; vep_done = 1'b1;
        @(negedge clk);
        vep_done = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || vep_start !== 1'b0 || upd_valid !== 1'b0 || bmu_x !== 3'd0) begin
            errors++; $display("FAIL stray_load: got in_ready=%b vep_start=%b upd_valid=%b bmu_x=%0d expected 1 0 0 0",
                               in_ready, vep_start, upd_valid, bmu_x);
        end
        pulse_start();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || epoch !== 3'd0) begin
            errors++; $display("FAIL start_busy_ign: got in_ready=%b busy=%b epoch=%0d expected 1 1 0", in_ready, busy, epoch);
        end
        load_vec(24'h555555, ok);
        give_bmu(3'd4, 3'd4);
        upd_ready = 1'b1;
        repeat (3) @(negedge clk);
        upd_ready = 1'b0;
        X_c = 3'd1; Y_c = 3'd1; vep_done = 1'b1; start = 1'b1;
        @(negedge clk);
        vep_done = 1'b0; start = 1'b0; X_c = '0; Y_c = '0;
        checks++;
        if ({bmu_x, bmu_y} !== {3'd4, 3'd4} || upd_valid !== 1'b1 || {upd_x, upd_y, upd_shift} !== {3'd4, 3'd1, 3'd4}) begin
            errors++; $display("FAIL stray_update: got bmu=(%0d,%0d) upd=(%0d,%0d,%0d) valid=%b expected (4,4) (4,1,4) 1",
                               bmu_x, bmu_y, upd_x, upd_y, upd_shift, upd_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, in_ready, vep_start, upd_valid, bmu_x, bmu_y, upd_x, upd_y, upd_shift, epoch} !== 23'b0
            || vep_vec !== 24'h0) begin
            errors++; $display("FAIL mid_rst: got ctrl=%b vec=%h expected all 0",
                               {busy, done, in_ready, vep_start, upd_valid, bmu_x, bmu_y, upd_x, upd_y, upd_shift, epoch}, vep_vec);
        end
        rst = 1'b0;
    endtask

`ifdef SOM_TORUS_WRAP_EN
    task automatic test_torus();
        bit ok, to, f07, f61; int viol;
        do_reset();
        pulse_start();
        for (int s = 0; s < 4; s++) begin
            load_vec(24'(s), ok);
            give_bmu(3'd4, 3'd4);
            collect(1'b0, to, viol);
        end
        load_vec(24'hABCDEF, ok);
        give_bmu(3'd7, 3'd0);
        collect(1'b0, to, viol);
        f07 = 1'b0; f61 = 1'b0;
        foreach (got_x[i]) begin
            if (got_x[i] == 3'd0 && got_y[i] == 3'd7) f07 = 1'b1;
            if (got_x[i] == 3'd6 && got_y[i] == 3'd1) f61 = 1'b1;
        end
        checks++;
        if (to || got_x.size() !== 9 || !f07 || !f61) begin
            errors++; $display("FAIL torus_wrap: got n=%0d has07=%b has61=%b expected 9 1 1", got_x.size(), f07, f61);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_corner_bmu();
        test_centre_bmu();
        test_stall();
        test_full_run();
        test_stray_and_rst();
`ifdef SOM_TORUS_WRAP_EN
        test_torus();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
